// File: rtl/ram_seq_writer_pkg.sv
// Shared types and sizes for the sequential RAM writer: state encoding,
// RAM write-port widths and the write-side bus payload.
package ram_seq_writer_pkg;

    localparam int unsigned ADDR_W        = 5;
    localparam int unsigned DATA_W        = 4;
    localparam int unsigned DEPTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One RAM write-port beat: enable, address and data travel together.
    typedef struct packed {
        logic              wren;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ram_wr_t;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a stability
// counter that only accepts a new level after DEBOUNCE_CYCLES steady cycles.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLOCK_50,
    input  logic KEY0,
    input  logic key_raw,
    output logic key_db
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Synchronizer resets to the released (high) level.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    // Count consecutive cycles the synchronized level differs from the
    // accepted one; any return to the accepted level restarts the count.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            cnt_q  <= '0;
            key_db <= 1'b1;
        end else if (sync_q[1] == key_db) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            key_db <= sync_q[1];
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ram_seq_writer.sv
// Drives the write side of an external 2-port RAM: single writes from a
// debounced push-button at an auto-incrementing pointer, or a whole-RAM fill.
module ram_seq_writer
    import ram_seq_writer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DEPTH           = DEPTH_DEFAULT
) (
    input  logic              CLOCK_50,
    input  logic              KEY0,
    input  logic              wr_key_n,
    input  logic              fill,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] fill_value,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic key_db;
    logic key_db_q;
    logic wr_req_c;

    state_t            state_q, state_d;
    ram_wr_t           wr_q, wr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [DATA_W-1:0] fill_val_q, fill_val_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .CLOCK_50(CLOCK_50),
        .KEY0    (KEY0),
        .key_raw (wr_key_n),
        .key_db  (key_db)
    );

    // Press = falling edge of the debounced level; a held key yields one request.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            key_db_q <= 1'b1;
        end else begin
            key_db_q <= key_db;
        end
    end

    assign wr_req_c = key_db_q & ~key_db;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q    <= ST_IDLE;
            wr_q       <= '0;
            ptr_q      <= '0;
            fill_cnt_q <= '0;
            fill_val_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            ptr_q      <= ptr_d;
            fill_cnt_q <= fill_cnt_d;
            fill_val_q <= fill_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state and next registered outputs; outputs reflect the state they
    // are registered into, so wren/busy/done line up with WRITE/FILL/DONE.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        wr_d.wren  = 1'b0;
        ptr_d      = ptr_q;
        fill_cnt_d = fill_cnt_q;
        fill_val_d = fill_val_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Fill wins over a coincident press; the press is dropped.
                if (fill) begin
                    state_d    = ST_FILL;
                    fill_cnt_d = '0;
                    fill_val_d = fill_value;
                    wr_d.wren  = 1'b1;
                    wr_d.addr  = '0;
                    wr_d.data  = fill_value;
                    busy_d     = 1'b1;
                end else if (wr_req_c) begin
                    state_d   = ST_WRITE;
                    wr_d.wren = 1'b1;
                    wr_d.addr = ptr_q;
                    wr_d.data = data;
                    ptr_d     = ptr_q + ADDR_W'(1);
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_FILL: begin
                if (fill_cnt_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    ptr_d   = '0;
                end else begin
                    fill_cnt_d = fill_cnt_q + ADDR_W'(1);
                    wr_d.wren  = 1'b1;
                    wr_d.addr  = fill_cnt_q + ADDR_W'(1);
                    wr_d.data  = fill_val_q;
                    busy_d     = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wraddress = wr_q.addr;
    assign wrdata    = wr_q.data;
    assign wren      = wr_q.wren;
    assign ptr       = ptr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ram_seq_writer.sv
// Directed bench for ram_seq_writer with a short debounce window.
module tb_ram_seq_writer;

    logic       CLOCK_50 = 1'b0;
    logic       KEY0;
    logic       wr_key_n;
    logic       fill;
    logic [3:0] data;
    logic [3:0] fill_value;
    logic [4:0] wraddress;
    logic [3:0] wrdata;
    logic       wren;
    logic [4:0] ptr;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    int         wr_cnt   = 0;
    int         done_cnt = 0;
    logic [4:0] addr_log[$];
    logic [3:0] data_log[$];

    ram_seq_writer #(
        .DEBOUNCE_CYCLES(4),
        .DEPTH          (32)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .KEY0      (KEY0),
        .wr_key_n  (wr_key_n),
        .fill      (fill),
        .data      (data),
        .fill_value(fill_value),
        .wraddress (wraddress),
        .wrdata    (wrdata),
        .wren      (wren),
        .ptr       (ptr),
        .busy      (busy),
        .done      (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Record every RAM write and done pulse, sampled mid-cycle.
    always @(negedge CLOCK_50) begin
        if (wren === 1'b1) begin
            wr_cnt++;
            addr_log.push_back(wraddress);
            data_log.push_back(wrdata);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic clear_log();
        wr_cnt   = 0;
        done_cnt = 0;
        addr_log.delete();
        data_log.delete();
    endtask

    task automatic apply_reset();
        KEY0 = 1'b0;
        tick(3);
        KEY0 = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        KEY0 = 1'b0; wr_key_n = 1'b1; fill = 1'b0; data = 4'h0; fill_value = 4'h0;
        tick(2);
        n_vec++; if (wren !== 1'b0)      begin n_err++; $display("FAIL reset_wren: got %0h want 0", wren); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %0h want 0", busy); end
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %0h want 0", done); end
        n_vec++; if (ptr !== 5'd0)       begin n_err++; $display("FAIL reset_ptr: got %0h want 0", ptr); end
        n_vec++; if (wraddress !== 5'd0) begin n_err++; $display("FAIL reset_wraddress: got %0h want 0", wraddress); end
        n_vec++; if (wrdata !== 4'd0)    begin n_err++; $display("FAIL reset_wrdata: got %0h want 0", wrdata); end
        KEY0 = 1'b1;
        clear_log();
        tick(10);
        n_vec++; if (wr_cnt !== 0) begin n_err++; $display("FAIL idle_no_write: got %0d writes want 0", wr_cnt); end
    endtask

    // Press at edge 0: sync 2 edges, debounce 4, edge detect, then wren at edge 7.
    task automatic test_single_write();
        logic exp_wren;
        clear_log();
        data = 4'hA;
        wr_key_n = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            exp_wren = (k == 7);
            n_vec++;
            if (wren !== exp_wren) begin n_err++; $display("FAIL single_latency k=%0d: got wren %0h want %0h", k, wren, exp_wren); end
            if (k == 7) begin
                n_vec++; if (wraddress !== 5'd0) begin n_err++; $display("FAIL single_addr: got %0h want 0", wraddress); end
                n_vec++; if (wrdata !== 4'hA)    begin n_err++; $display("FAIL single_data: got %0h want a", wrdata); end
            end
        end
        data = 4'h3;
        wr_key_n = 1'b1;
        tick(12);
        n_vec++; if (wr_cnt !== 1)       begin n_err++; $display("FAIL single_count: got %0d want 1", wr_cnt); end
        n_vec++; if (ptr !== 5'd1)       begin n_err++; $display("FAIL single_ptr: got %0h want 1", ptr); end
        n_vec++; if (wraddress !== 5'd0) begin n_err++; $display("FAIL single_hold_addr: got %0h want 0", wraddress); end
        n_vec++; if (wrdata !== 4'hA)    begin n_err++; $display("FAIL single_hold_data: got %0h want a", wrdata); end
    endtask

    task automatic test_bounce();
        clear_log();
        data = 4'h7;
        repeat (5) begin
            wr_key_n = 1'b0; tick(2);
            wr_key_n = 1'b1; tick(2);
        end
        tick(8);
        n_vec++; if (wr_cnt !== 0) begin n_err++; $display("FAIL bounce_no_write: got %0d writes want 0", wr_cnt); end
        wr_key_n = 1'b0; tick(10);
        wr_key_n = 1'b1; tick(12);
        n_vec++; if (wr_cnt !== 1) begin n_err++; $display("FAIL bounce_hold_count: got %0d want 1", wr_cnt); end
        n_vec++; if (addr_log[0] !== 5'd1) begin n_err++; $display("FAIL bounce_addr: got %0h want 1", addr_log[0]); end
        n_vec++; if (data_log[0] !== 4'h7) begin n_err++; $display("FAIL bounce_data: got %0h want 7", data_log[0]); end
        n_vec++; if (ptr !== 5'd2) begin n_err++; $display("FAIL bounce_ptr: got %0h want 2", ptr); end
    endtask

    task automatic test_wrap();
        apply_reset();
        clear_log();
        for (int i = 0; i < 33; i++) begin
            data = 4'(i);
            wr_key_n = 1'b0; tick(8);
            wr_key_n = 1'b1; tick(9);
        end
        n_vec++; if (wr_cnt !== 33) begin n_err++; $display("FAIL wrap_count: got %0d want 33", wr_cnt); end
        for (int i = 0; i < 33; i++) begin
            n_vec++; if (addr_log[i] !== 5'(i)) begin n_err++; $display("FAIL wrap_addr[%0d]: got %0h want %0h", i, addr_log[i], 5'(i)); end
            n_vec++; if (data_log[i] !== 4'(i)) begin n_err++; $display("FAIL wrap_data[%0d]: got %0h want %0h", i, data_log[i], 4'(i)); end
        end
        n_vec++; if (ptr !== 5'd1) begin n_err++; $display("FAIL wrap_ptr: got %0h want 1", ptr); end
    endtask

    task automatic test_fill();
        clear_log();
        fill_value = 4'h5;
        fill = 1'b1;
        tick(1);
        fill = 1'b0;
        fill_value = 4'h9;
        for (int k = 0; k < 32; k++) begin
            @(negedge CLOCK_50);
            n_vec++; if (wren !== 1'b1)      begin n_err++; $display("FAIL fill_wren[%0d]: got %0h want 1", k, wren); end
            n_vec++; if (busy !== 1'b1)      begin n_err++; $display("FAIL fill_busy[%0d]: got %0h want 1", k, busy); end
            n_vec++; if (wraddress !== 5'(k)) begin n_err++; $display("FAIL fill_addr[%0d]: got %0h want %0h", k, wraddress, 5'(k)); end
            n_vec++; if (wrdata !== 4'h5)    begin n_err++; $display("FAIL fill_data[%0d]: got %0h want 5", k, wrdata); end
            n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL fill_early_done[%0d]: got %0h want 0", k, done); end
        end
        @(negedge CLOCK_50);
        n_vec++; if (wren !== 1'b0) begin n_err++; $display("FAIL fill_done_wren: got %0h want 0", wren); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL fill_done_pulse: got %0h want 1", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fill_done_busy: got %0h want 0", busy); end
        n_vec++; if (ptr !== 5'd0)  begin n_err++; $display("FAIL fill_done_ptr: got %0h want 0", ptr); end
        @(negedge CLOCK_50);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL fill_done_width: got %0h want 0", done); end
        tick(3);
        n_vec++; if (wr_cnt !== 32)  begin n_err++; $display("FAIL fill_count: got %0d want 32", wr_cnt); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL fill_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_fill_discard();
        // Press lands entirely inside the fill.
        clear_log();
        fill_value = 4'h6;
        fill = 1'b1; tick(1);
        fill = 1'b0; tick(2);
        wr_key_n = 1'b0; tick(8);
        wr_key_n = 1'b1; tick(40);
        n_vec++; if (wr_cnt !== 32)  begin n_err++; $display("FAIL discard_count: got %0d want 32", wr_cnt); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL discard_done: got %0d want 1", done_cnt); end
        n_vec++; if (ptr !== 5'd0)   begin n_err++; $display("FAIL discard_ptr: got %0h want 0", ptr); end
        // Request and fill in the same IDLE cycle (request seen after edge 6).
        clear_log();
        data = 4'h3;
        fill_value = 4'hC;
        wr_key_n = 1'b0; tick(6);
        fill = 1'b1; tick(1);
        fill = 1'b0; tick(2);
        wr_key_n = 1'b1; tick(40);
        n_vec++; if (wr_cnt !== 32)        begin n_err++; $display("FAIL collide_count: got %0d want 32", wr_cnt); end
        n_vec++; if (addr_log[0] !== 5'd0) begin n_err++; $display("FAIL collide_first_addr: got %0h want 0", addr_log[0]); end
        n_vec++; if (data_log[0] !== 4'hC) begin n_err++; $display("FAIL collide_first_data: got %0h want c", data_log[0]); end
        n_vec++; if (done_cnt !== 1)       begin n_err++; $display("FAIL collide_done: got %0d want 1", done_cnt); end
        n_vec++; if (ptr !== 5'd0)         begin n_err++; $display("FAIL collide_ptr: got %0h want 0", ptr); end
    endtask

    task automatic test_reset_in_fill();
        bit found = 1'b0;
        clear_log();
        fill_value = 4'h7;
        fill = 1'b1; tick(1);
        fill = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge CLOCK_50);
            if (wren === 1'b1 && wraddress === 5'd10) found = 1'b1;
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL rstfill_reach_addr10: got no write to 10 want one"); end
        KEY0 = 1'b0;
        #1;
        n_vec++; if (wren !== 1'b0)      begin n_err++; $display("FAIL rstfill_wren: got %0h want 0", wren); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rstfill_busy: got %0h want 0", busy); end
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL rstfill_done: got %0h want 0", done); end
        n_vec++; if (ptr !== 5'd0)       begin n_err++; $display("FAIL rstfill_ptr: got %0h want 0", ptr); end
        n_vec++; if (wraddress !== 5'd0) begin n_err++; $display("FAIL rstfill_wraddress: got %0h want 0", wraddress); end
        n_vec++; if (wrdata !== 4'd0)    begin n_err++; $display("FAIL rstfill_wrdata: got %0h want 0", wrdata); end
        clear_log();
        tick(2);
        KEY0 = 1'b1;
        tick(40);
        n_vec++; if (wr_cnt !== 0)   begin n_err++; $display("FAIL rstfill_no_write: got %0d want 0", wr_cnt); end
        n_vec++; if (done_cnt !== 0) begin n_err++; $display("FAIL rstfill_no_done: got %0d want 0", done_cnt); end
        n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rstfill_idle_busy: got %0h want 0", busy); end
    endtask

    task automatic test_held_through_reset();
        data = 4'h3;
        KEY0 = 1'b0;
        wr_key_n = 1'b0;
        tick(3);
        KEY0 = 1'b1;
        clear_log();
        tick(30);
        n_vec++; if (wr_cnt !== 1)         begin n_err++; $display("FAIL held_count: got %0d want 1", wr_cnt); end
        n_vec++; if (addr_log[0] !== 5'd0) begin n_err++; $display("FAIL held_addr: got %0h want 0", addr_log[0]); end
        n_vec++; if (data_log[0] !== 4'h3) begin n_err++; $display("FAIL held_data: got %0h want 3", data_log[0]); end
        n_vec++; if (ptr !== 5'd1)         begin n_err++; $display("FAIL held_ptr: got %0h want 1", ptr); end
        wr_key_n = 1'b1;
        tick(12);
        n_vec++; if (wr_cnt !== 1) begin n_err++; $display("FAIL held_release_count: got %0d want 1", wr_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_bounce();
        test_wrap();
        test_fill();
        test_fill_discard();
        test_reset_in_fill();
        test_held_through_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_seq_writer.md
RAM_SEQ_WRITER -- requirements
Module: ram_seq_writer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles before a key level is accepted (20 ms at 50 MHz).
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of RAM words written by a fill.
REQ-003 SHALL have port CLOCK_50  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port KEY0  input  1  meaning reset, asynchronous, active-low.
REQ-005 SHALL have port wr_key_n  input  1  meaning raw push-button, active-low, asynchronous to CLOCK_50; a press requests a single write.
REQ-006 SHALL have port fill  input  1  meaning level request to fill the whole RAM with fill_value.
REQ-007 SHALL have port data  input  4  meaning word for a single write.
REQ-008 SHALL have port fill_value  input  4  meaning word for a fill.
REQ-009 SHALL have port wraddress  output  5  meaning RAM write address, registered.
REQ-010 SHALL have port wrdata  output  4  meaning RAM write data, registered.
REQ-011 SHALL have port wren  output  1  meaning RAM write enable, registered, one cycle per word.
REQ-012 SHALL have port ptr  output  5  meaning next single-write address, for HEX display.
REQ-013 SHALL have port busy  output  1  meaning high while in FILL.
REQ-014 SHALL have port done  output  1  meaning one-cycle pulse at fill completion.

Function
REQ-015 SHALL pass wr_key_n through a 2-flop synchronizer, then accept a new level only after it is stable for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 SHALL form a write request as the 1->0 transition of the debounced key; a held key generates exactly one request.
REQ-017 SHALL implement states IDLE, WRITE, FILL, DONE.
REQ-018 IDLE: fill=1 -> FILL with fill counter 0; else a write request -> WRITE; else stay.
REQ-019 When fill=1 and a write request occur in the same IDLE cycle, SHALL take fill and drop the write request.
REQ-020 WRITE (one cycle): wren=1, wraddress=ptr, wrdata=data as sampled in the request cycle; ptr <= ptr+1 mod 32; next state IDLE.
REQ-021 Latency: a request in cycle N SHALL produce wren high in cycle N+1.
REQ-022 ptr SHALL wrap from 31 to 0 without a stall.
REQ-023 FILL: each cycle wren=1, wraddress=counter, wrdata=fill_value sampled at FILL entry, counter+1; after address DEPTH-1 -> DONE.
REQ-024 busy SHALL be high in every FILL cycle, so wren is high for exactly DEPTH consecutive cycles.
REQ-025 DONE (one cycle): done=1, wren=0, ptr <= 0; next state IDLE.
REQ-026 Write requests arriving in FILL or DONE SHALL be discarded, not queued.
REQ-027 fill held high after DONE SHALL start a new fill from IDLE; changes to fill inside FILL SHALL be ignored.
REQ-028 wren SHALL be 0 in IDLE; wraddress/wrdata SHALL hold their last values when wren=0.

Reset
REQ-029 KEY0=0 SHALL immediately force: state IDLE, wren=0, busy=0, done=0, ptr=0, wraddress=0, wrdata=0, fill counter 0, debounce counter 0, synchronizer and debounced key = 1 (released).
REQ-030 Reset during FILL SHALL abort the fill with no further writes; no done pulse is issued.
REQ-031 After KEY0 rises, a key already held low SHALL produce one request after the debounce time.

Structure
REQ-032 A shared package SHALL hold the state encoding, ADDR_W=5, DATA_W=4, DEPTH default.
REQ-033 Synchronizer plus debounce SHALL be one sub-module, key_debounce (CLOCK_50, KEY0, raw key in, debounced level out).
REQ-034 There SHALL be no RAM inside the block; it drives an external 2-port RAM write side.

Verification (sim with DEBOUNCE_CYCLES=4)
REQ-035 Press wr_key_n with data=4'hA, ptr=0 -> exactly one wren pulse, wraddress=0, wrdata=A; ptr=1.
REQ-036 wr_key_n bouncing with 2-cycle glitches -> no wren; hold low 10 cycles -> exactly one wren.
REQ-037 33 clean presses, data=press index mod 16 -> addresses 0..31 then 0; ptr=1 at end.
REQ-038 fill=1 for 1 cycle, fill_value=4'h5 -> 32 consecutive wren cycles at addresses 0..31 with data 5, busy high throughout, done pulse one cycle after, ptr=0.
REQ-039 Key press during FILL -> no extra write after DONE; fill and request in the same cycle -> fill only.
REQ-040 KEY0 low at FILL address 10 -> wren=0 immediately, busy=0, no done; all outputs at reset values.
